// File: rtl/aip_slave_if.sv
// aip_slave_if: host-side responder for the convolution core.
// Owns input memories X/Y, output memory Z, the Csize register and the
// STATUS / IP_ID registers, and raises an active-low interrupt from masked
// done flags.
// Optional feature macro: AIP_ERR_INT_EN (adds an error flag in flags[1]).
// Host handshake: a strobe (write or read) is accepted on every rising edge
// where it is high together with en_s; there is no back-pressure. Read data
// appears on data_out in the cycle after the read strobe. Write beats read.
module aip_slave_if #(
   parameter int          DATAWIDTH   = 32,
   parameter int          MEM_DEPTH   = 9,
   parameter int          ADDR_W      = 4,
   parameter logic [31:0] IP_ID_VALUE = 32'h1000500A
) (
   input  logic                 clk,
   input  logic                 rst_a,
   input  logic                 en_s,
   input  logic [DATAWIDTH-1:0] data_in,
   output logic [DATAWIDTH-1:0] data_out,
   input  logic                 write,
   input  logic                 read,
   input  logic                 start,
   input  logic [4:0]           conf_dbus,
   output logic                 int_req,
   output logic                 core_start,
   input  logic                 core_done,
   input  logic [ADDR_W-1:0]    core_x_addr,
   input  logic [ADDR_W-1:0]    core_y_addr,
   output logic [DATAWIDTH-1:0] core_x_data,
   output logic [DATAWIDTH-1:0] core_y_data,
   input  logic                 core_z_we,
   input  logic [ADDR_W-1:0]    core_z_addr,
   input  logic [DATAWIDTH-1:0] core_z_data,
   output logic [DATAWIDTH-1:0] cfg_size
);

   localparam logic [4:0] C_MDATAX = 5'd0;
   localparam logic [4:0] C_ADATAX = 5'd1;
   localparam logic [4:0] C_MDATAY = 5'd2;
   localparam logic [4:0] C_ADATAY = 5'd3;
   localparam logic [4:0] C_MDATAZ = 5'd4;
   localparam logic [4:0] C_ADATAZ = 5'd5;
   localparam logic [4:0] C_CSIZE  = 5'd6;
   localparam logic [4:0] C_ASIZE  = 5'd7;
   localparam logic [4:0] C_STATUS = 5'd30;
   localparam logic [4:0] C_IP_ID  = 5'd31;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);

`ifdef AIP_ERR_INT_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   // Pointers wrap to 0 after the last word; out-of-range pointers keep
   // counting modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      if (p == LAST_IDX) return '0;
      else               return p + ADDR_W'(1);
   endfunction

   logic [DATAWIDTH-1:0] mem_x_q [MEM_DEPTH];
   logic [DATAWIDTH-1:0] mem_y_q [MEM_DEPTH];
   logic [DATAWIDTH-1:0] mem_z_q [MEM_DEPTH];

   logic [ADDR_W-1:0]    ptr_x_q, ptr_x_d;
   logic [ADDR_W-1:0]    ptr_y_q, ptr_y_d;
   logic [ADDR_W-1:0]    ptr_z_q, ptr_z_d;
   logic [ADDR_W-1:0]    ptr_s_q, ptr_s_d;
   logic [DATAWIDTH-1:0] csize_q, csize_d;
   logic [7:0]           mask_q, mask_d;
   logic [7:0]           flags_q, flags_d;
   logic                 busy_q, busy_d;
   logic                 core_start_q, core_start_d;
   logic                 int_req_q, int_req_d;
   logic [DATAWIDTH-1:0] data_out_q, data_out_d;

   logic                 host_wr, host_rd, start_ok, start_busy;
   logic                 x_we, y_we, err_evt;
   logic                 x_in, y_in, z_in;
   logic [7:0]           mask_eff;
   logic [DATAWIDTH-1:0] status_word;

   assign host_wr    = en_s & write;
   assign host_rd    = en_s & read & ~write;
   assign start_ok   = en_s & start & ~busy_q;
   assign start_busy = en_s & start & busy_q;

   assign x_in = (ptr_x_q <= LAST_IDX);
   assign y_in = (ptr_y_q <= LAST_IDX);
   assign z_in = (ptr_z_q <= LAST_IDX);

   // Without the error feature mask[1] is kept for readback only.
   assign mask_eff    = ERR_EN ? mask_q : (mask_q & 8'hFD);
   assign status_word = DATAWIDTH'({8'h00, mask_q, 7'h00, busy_q, flags_q});

   // Host decode, flag/busy bookkeeping and interrupt next-state.
   always_comb begin
      ptr_x_d      = ptr_x_q;
      ptr_y_d      = ptr_y_q;
      ptr_z_d      = ptr_z_q;
      ptr_s_d      = ptr_s_q;
      csize_d      = csize_q;
      mask_d       = mask_q;
      flags_d      = flags_q;
      busy_d       = busy_q;
      data_out_d   = data_out_q;
      core_start_d = 1'b0;
      x_we         = 1'b0;
      y_we         = 1'b0;
      err_evt      = 1'b0;

      if (host_wr) begin
         case (conf_dbus)
            C_MDATAX: begin
               x_we    = x_in;
               err_evt = ~x_in;
               ptr_x_d = ptr_inc(ptr_x_q);
            end
            C_MDATAY: begin
               y_we    = y_in;
               err_evt = ~y_in;
               ptr_y_d = ptr_inc(ptr_y_q);
            end
            C_MDATAZ: err_evt = 1'b1;
            C_ADATAX: ptr_x_d = data_in[ADDR_W-1:0];
            C_ADATAY: ptr_y_d = data_in[ADDR_W-1:0];
            C_ADATAZ: ptr_z_d = data_in[ADDR_W-1:0];
            C_ASIZE:  ptr_s_d = data_in[ADDR_W-1:0];
            C_CSIZE:  csize_d = data_in;
            C_STATUS: begin
               mask_d  = data_in[23:16];
               flags_d = flags_q & ~data_in[7:0];
            end
            default: ;
         endcase
      end else if (host_rd) begin
         case (conf_dbus)
            C_MDATAX: begin
               data_out_d = x_in ? mem_x_q[ptr_x_q] : '0;
               err_evt    = ~x_in;
               ptr_x_d    = ptr_inc(ptr_x_q);
            end
            C_MDATAY: begin
               data_out_d = y_in ? mem_y_q[ptr_y_q] : '0;
               err_evt    = ~y_in;
               ptr_y_d    = ptr_inc(ptr_y_q);
            end
            C_MDATAZ: begin
               data_out_d = z_in ? mem_z_q[ptr_z_q] : '0;
               err_evt    = ~z_in;
               ptr_z_d    = ptr_inc(ptr_z_q);
            end
            C_ADATAX: data_out_d = DATAWIDTH'(ptr_x_q);
            C_ADATAY: data_out_d = DATAWIDTH'(ptr_y_q);
            C_ADATAZ: data_out_d = DATAWIDTH'(ptr_z_q);
            C_ASIZE:  data_out_d = DATAWIDTH'(ptr_s_q);
            C_CSIZE:  data_out_d = csize_q;
            C_STATUS: data_out_d = status_word;
            C_IP_ID:  data_out_d = DATAWIDTH'(IP_ID_VALUE);
            default:  data_out_d = '0;
         endcase
      end

      if (start_busy) err_evt = 1'b1;

      // done ends the current run; a start accepted this cycle opens a new one.
      if (core_done) busy_d = 1'b0;
      if (start_ok) begin
         busy_d       = 1'b1;
         core_start_d = 1'b1;
      end

      // Setting a flag takes priority over a same-cycle host clear.
      if (core_done) flags_d[0] = 1'b1;
      if (err_evt & ERR_EN) flags_d[1] = 1'b1;

      int_req_d = ~|(flags_q & mask_eff);
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_a) begin
         ptr_x_q      <= '0;
         ptr_y_q      <= '0;
         ptr_z_q      <= '0;
         ptr_s_q      <= '0;
         csize_q      <= '0;
         mask_q       <= '0;
         flags_q      <= '0;
         busy_q       <= 1'b0;
         core_start_q <= 1'b0;
         int_req_q    <= 1'b1;
         data_out_q   <= '0;
      end else begin
         ptr_x_q      <= ptr_x_d;
         ptr_y_q      <= ptr_y_d;
         ptr_z_q      <= ptr_z_d;
         ptr_s_q      <= ptr_s_d;
         csize_q      <= csize_d;
         mask_q       <= mask_d;
         flags_q      <= flags_d;
         busy_q       <= busy_d;
         core_start_q <= core_start_d;
         int_req_q    <= int_req_d;
         data_out_q   <= data_out_d;
      end
   end

   // Memory arrays: contents survive reset, but no write lands during it.
   always_ff @(posedge clk) begin
      if (!rst_a) begin
         if (x_we) mem_x_q[ptr_x_q] <= data_in;
         if (y_we) mem_y_q[ptr_y_q] <= data_in;
         if (core_z_we && (core_z_addr <= LAST_IDX)) mem_z_q[core_z_addr] <= core_z_data;
      end
   end

   assign core_x_data = (core_x_addr <= LAST_IDX) ? mem_x_q[core_x_addr] : '0;
   assign core_y_data = (core_y_addr <= LAST_IDX) ? mem_y_q[core_y_addr] : '0;
   assign data_out    = data_out_q;
   assign int_req     = int_req_q;
   assign core_start  = core_start_q;
   assign cfg_size    = csize_q;

endmodule

// File: tb/tb_aip_slave_if.sv
// Directed bench for aip_slave_if: one task per scenario, inline checks.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_aip_slave_if;

   localparam int DW = 32;
   localparam int AW = 4;

`ifdef AIP_ERR_INT_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_a;
   logic          en_s;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          write;
   logic          read;
   logic          start;
   logic [4:0]    conf_dbus;
   logic          int_req;
   logic          core_start;
   logic          core_done;
   logic [AW-1:0] core_x_addr;
   logic [AW-1:0] core_y_addr;
   logic [DW-1:0] core_x_data;
   logic [DW-1:0] core_y_data;
   logic          core_z_we;
   logic [AW-1:0] core_z_addr;
   logic [DW-1:0] core_z_data;
   logic [DW-1:0] cfg_size;

   int tests_run;
   int tests_failed;

   aip_slave_if #(.DATAWIDTH(DW), .MEM_DEPTH(9), .ADDR_W(AW), .IP_ID_VALUE(32'h1000500A)) dut (
      .clk         (clk),
      .rst_a       (rst_a),
      .en_s        (en_s),
      .data_in     (data_in),
      .data_out    (data_out),
      .write       (write),
      .read        (read),
      .start       (start),
      .conf_dbus   (conf_dbus),
      .int_req     (int_req),
      .core_start  (core_start),
      .core_done   (core_done),
      .core_x_addr (core_x_addr),
      .core_y_addr (core_y_addr),
      .core_x_data (core_x_data),
      .core_y_data (core_y_data),
      .core_z_we   (core_z_we),
      .core_z_addr (core_z_addr),
      .core_z_data (core_z_data),
      .cfg_size    (cfg_size)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
      $fatal(1, "time limit");
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic host_write(input logic [4:0] c, input logic [DW-1:0] d);
      conf_dbus = c;
      data_in   = d;
      write     = 1'b1;
      @(posedge clk);
      #1;
      write = 1'b0;
   endtask

   task automatic host_read(input logic [4:0] c, output logic [DW-1:0] d);
      conf_dbus = c;
      read      = 1'b1;
      @(posedge clk);
      #1;
      read = 1'b0;
      d    = data_out;
   endtask

   task automatic test_reset();
      logic [DW-1:0] r;
      rst_a = 1'b1;
      idle(3);
      tests_run++;
      if (data_out !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_data_out: got %h want %h", data_out, 32'h0);
      end
      tests_run++;
      if (int_req !== 1'b1 || core_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_irq_start: got int_req=%b core_start=%b want 1/0", int_req, core_start);
      end
      tests_run++;
      if (cfg_size !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_cfg_size: got %h want %h", cfg_size, 32'h0);
      end
      rst_a = 1'b0;
      idle(1);
      host_read(5'd31, r);
      tests_run++;
      if (r !== 32'h1000500A) begin
         tests_failed++;
         $display("FAIL ip_id: got %h want %h", r, 32'h1000500A);
      end
      host_read(5'd30, r);
      tests_run++;
      if (r !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_status: got %h want %h", r, 32'h0);
      end
   endtask

   task automatic test_mem_xy();
      logic [DW-1:0] xv [5];
      logic [DW-1:0] yv [4];
      logic [DW-1:0] r;
      xv = '{32'd3, 32'd1, 32'd4, 32'd0, 32'd2};
      yv = '{32'd2, 32'd2, 32'd1, 32'd3};
      host_write(5'd1, 32'd0);
      for (int i = 0; i < 5; i++) host_write(5'd0, xv[i]);
      host_write(5'd3, 32'd0);
      for (int i = 0; i < 4; i++) host_write(5'd2, yv[i]);
      core_x_addr = 4'd2;
      core_y_addr = 4'd3;
      #1;
      tests_run++;
      if (core_x_data !== 32'd4) begin
         tests_failed++;
         $display("FAIL core_x_data: got %0d want 4", core_x_data);
      end
      tests_run++;
      if (core_y_data !== 32'd3) begin
         tests_failed++;
         $display("FAIL core_y_data: got %0d want 3", core_y_data);
      end
      // Back-to-back read burst from X[0].
      host_write(5'd1, 32'd0);
      conf_dbus = 5'd0;
      read      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if (data_out !== xv[i]) begin
            tests_failed++;
            $display("FAIL x_readback[%0d]: got %0d want %0d", i, data_out, xv[i]);
         end
      end
      read = 1'b0;
      // Write and read together: write wins, data_out holds.
      conf_dbus = 5'd6;
      data_in   = 32'h55;
      write     = 1'b1;
      read      = 1'b1;
      idle(1);
      write = 1'b0;
      read  = 1'b0;
      tests_run++;
      if (data_out !== 32'd2 || cfg_size !== 32'h55) begin
         tests_failed++;
         $display("FAIL wr_rd_collide: got data_out=%h cfg_size=%h want 2/55", data_out, cfg_size);
      end
      // Unmapped code reads 0.
      host_read(5'd10, r);
      tests_run++;
      if (r !== 32'h0) begin
         tests_failed++;
         $display("FAIL unmapped_read: got %h want 0", r);
      end
   endtask

   task automatic test_cfg_start();
      logic [DW-1:0] r;
      host_write(5'd6, (32'd4 << 5) | 32'd5);
      tests_run++;
      if (cfg_size !== 32'h85) begin
         tests_failed++;
         $display("FAIL cfg_size: got %h want 85", cfg_size);
      end
      host_write(5'd30, 32'h00010000);
      // Strobes with en_s low are ignored.
      en_s  = 1'b0;
      start = 1'b1;
      idle(1);
      start = 1'b0;
      tests_run++;
      if (core_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_en_low: got core_start=%b want 0", core_start);
      end
      host_read(5'd31, r);
      tests_run++;
      if (r !== 32'h0) begin
         tests_failed++;
         $display("FAIL read_en_low: got %h want 0 (held)", r);
      end
      en_s  = 1'b1;
      start = 1'b1;
      idle(1);
      start = 1'b0;
      tests_run++;
      if (core_start !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_pulse: got core_start=%b want 1", core_start);
      end
      idle(1);
      tests_run++;
      if (core_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_one_cycle: got core_start=%b want 0", core_start);
      end
      host_read(5'd30, r);
      tests_run++;
      if (r !== 32'h00010100) begin
         tests_failed++;
         $display("FAIL status_busy: got %h want %h", r, 32'h00010100);
      end
      start = 1'b1;
      idle(1);
      start = 1'b0;
      tests_run++;
      if (core_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_while_busy: got core_start=%b want 0", core_start);
      end
      idle(1);
   endtask

   task automatic test_z_done();
      logic [DW-1:0] r;
      logic [DW-1:0] exp_st;
      for (int k = 0; k < 9; k++) begin
         core_z_we   = 1'b1;
         core_z_addr = AW'(k);
         core_z_data = DW'(k * 7);
         idle(1);
      end
      core_z_we = 1'b0;
      core_done = 1'b1;
      idle(1);
      core_done = 1'b0;
      tests_run++;
      if (int_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL irq_lag: got int_req=%b want 1", int_req);
      end
      idle(1);
      tests_run++;
      if (int_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL irq_assert: got int_req=%b want 0", int_req);
      end
      exp_st = 32'h00010001 | (ERR_EN ? 32'h2 : 32'h0);
      host_read(5'd30, r);
      tests_run++;
      if (r !== exp_st) begin
         tests_failed++;
         $display("FAIL status_done: got %h want %h", r, exp_st);
      end
      host_write(5'd5, 32'd0);
      for (int k = 0; k < 9; k++) begin
         host_read(5'd4, r);
         tests_run++;
         if (r !== DW'(k * 7)) begin
            tests_failed++;
            $display("FAIL z_readback[%0d]: got %0d want %0d", k, r, k * 7);
         end
      end
      // Host write to Z is dropped and the pointer stays put.
      host_write(5'd5, 32'd1);
      host_write(5'd4, 32'hDEAD);
      host_read(5'd4, r);
      tests_run++;
      if (r !== 32'd7) begin
         tests_failed++;
         $display("FAIL z_write_drop: got %h want 7", r);
      end
      // Core write and host read of Z[3] in the same cycle: old value.
      host_write(5'd5, 32'd3);
      core_z_we   = 1'b1;
      core_z_addr = 4'd3;
      core_z_data = 32'd99;
      conf_dbus   = 5'd4;
      read        = 1'b1;
      idle(1);
      read      = 1'b0;
      core_z_we = 1'b0;
      tests_run++;
      if (data_out !== 32'd21) begin
         tests_failed++;
         $display("FAIL z_collide_old: got %0d want 21", data_out);
      end
      host_write(5'd5, 32'd3);
      host_read(5'd4, r);
      tests_run++;
      if (r !== 32'd99) begin
         tests_failed++;
         $display("FAIL z_collide_new: got %0d want 99", r);
      end
   endtask

   task automatic test_clear();
      logic [DW-1:0] r;
      host_write(5'd30, 32'h00010003);
      idle(1);
      tests_run++;
      if (int_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL irq_clear: got int_req=%b want 1", int_req);
      end
      core_done = 1'b1;
      host_write(5'd30, 32'h00010001);
      core_done = 1'b0;
      host_read(5'd30, r);
      tests_run++;
      if (r !== 32'h00010001) begin
         tests_failed++;
         $display("FAIL set_beats_clear: got %h want %h", r, 32'h00010001);
      end
      tests_run++;
      if (int_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL irq_after_set: got int_req=%b want 0", int_req);
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] r;
      logic [DW-1:0] exp_st;
      host_write(5'd30, 32'h00020003);
      host_write(5'd1, 32'd8);
      host_write(5'd0, 32'hA);
      host_write(5'd0, 32'hB);
      core_x_addr = 4'd8;
      #1;
      tests_run++;
      if (core_x_data !== 32'hA) begin
         tests_failed++;
         $display("FAIL wrap_last: got %h want a", core_x_data);
      end
      core_x_addr = 4'd0;
      #1;
      tests_run++;
      if (core_x_data !== 32'hB) begin
         tests_failed++;
         $display("FAIL wrap_first: got %h want b", core_x_data);
      end
      host_write(5'd1, 32'd15);
      host_read(5'd0, r);
      tests_run++;
      if (r !== 32'h0) begin
         tests_failed++;
         $display("FAIL oor_read15: got %h want 0", r);
      end
      host_read(5'd0, r);
      tests_run++;
      if (r !== 32'hB) begin
         tests_failed++;
         $display("FAIL ptr_mod_wrap: got %h want b", r);
      end
      host_write(5'd1, 32'd12);
      host_read(5'd0, r);
      tests_run++;
      if (r !== 32'h0) begin
         tests_failed++;
         $display("FAIL oor_read12: got %h want 0", r);
      end
      idle(1);
      tests_run++;
      if (int_req !== ~ERR_EN) begin
         tests_failed++;
         $display("FAIL err_irq: got int_req=%b want %b", int_req, ~ERR_EN);
      end
      exp_st = 32'h00020000 | (ERR_EN ? 32'h2 : 32'h0);
      host_read(5'd30, r);
      tests_run++;
      if (r !== exp_st) begin
         tests_failed++;
         $display("FAIL err_status: got %h want %h", r, exp_st);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] r;
      rst_a = 1'b1;
      start = 1'b1;
      idle(1);
      start = 1'b0;
      tests_run++;
      if (core_start !== 1'b0 || int_req !== 1'b1 || cfg_size !== 32'h0 || data_out !== 32'h0) begin
         tests_failed++;
         $display("FAIL mid_reset: got core_start=%b int_req=%b cfg_size=%h data_out=%h want 0/1/0/0",
                  core_start, int_req, cfg_size, data_out);
      end
      idle(1);
      rst_a = 1'b0;
      tests_run++;
      if (core_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_nostart: got core_start=%b want 0", core_start);
      end
      host_read(5'd30, r);
      tests_run++;
      if (r !== 32'h0) begin
         tests_failed++;
         $display("FAIL mid_reset_status: got %h want 0", r);
      end
      host_read(5'd0, r);
      tests_run++;
      if (r !== 32'hB) begin
         tests_failed++;
         $display("FAIL mem_retained: got %h want b", r);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_a        = 1'b1;
      en_s         = 1'b1;
      data_in      = '0;
      write        = 1'b0;
      read         = 1'b0;
      start        = 1'b0;
      conf_dbus    = '0;
      core_done    = 1'b0;
      core_x_addr  = '0;
      core_y_addr  = '0;
      core_z_we    = 1'b0;
      core_z_addr  = '0;
      core_z_data  = '0;
      test_reset();
      test_mem_xy();
      test_cfg_start();
      test_z_done();
      test_clear();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/aip_slave_if.md
Name: aip_slave_if

Overview:
Responder side of the AIP host protocol for the convolution core. Decodes conf_dbus/read/write/start strobes from the host and owns the core's memories and registers: host-written input memories X and Y, core-written output memory Z, one size configuration register, and the STATUS/IP_ID registers. Drives an active-low interrupt request from masked done flags. Sits between the host bus and the convolution datapath.

Parameters:
DATAWIDTH, 32, host data bus width
MEM_DEPTH, 9, words per memory (X, Y, Z)
ADDR_W, 4, pointer width; must satisfy 2^ADDR_W >= MEM_DEPTH
IP_ID_VALUE, 32'h1000500A, constant returned on IP_ID read

Ports:
clk  in  1  clock; all logic on the rising edge
rst_a  in  1  reset; synchronous, active-high (name kept, polarity fixed)
en_s  in  1  host strobes ignored while low; core-side inputs still processed
data_in  in  DATAWIDTH  host write data
data_out  out  DATAWIDTH  registered host read data
write  in  1  host write strobe, one word per cycle high
read  in  1  host read strobe, one word per cycle high
start  in  1  host start strobe
conf_dbus  in  5  target select
int_req  out  1  interrupt request, active-low
core_start  out  1  one-cycle start pulse to core
core_done  in  1  one-cycle done pulse from core
core_x_addr / core_y_addr  in  ADDR_W  core read addresses
core_x_data / core_y_data  out  DATAWIDTH  combinational read of X/Y
core_z_we  in  1  core write enable for Z
core_z_addr  in  ADDR_W  Z write address
core_z_data  in  DATAWIDTH  Z write data
cfg_size  out  DATAWIDTH  Csize register contents

Behaviour:
- Map: 0 MdataX, 1 AdataX, 2 MdataY, 3 AdataY, 4 MdataZ, 5 AdataZ, 6 Csize, 7 Asize, 30 STATUS, 31 IP_ID. Other codes: writes ignored, reads return 0.
- Reset: data_out=0, int_req=1, core_start=0, mask=0, flags=0, busy=0, all pointers=0, Csize=0. Memory contents are not reset.
- Pointer write (odd codes 1,3,5,7): pointer <= data_in[ADDR_W-1:0]. The Asize pointer is stored but Csize is a single word.
- Memory write (conf 0/2 with write=1): mem[ptr] <= data_in, then ptr+1. Writes to MdataZ are dropped and the pointer does not move. Csize write loads the register.
- Read: when read=1, data_out is updated at that clock edge, so it is valid in the cycle after the strobe. Memory reads (X, Y, Z readable) use mem[ptr], then ptr+1.
- Pointer wrap: the increment from MEM_DEPTH-1 goes to 0. If ptr >= MEM_DEPTH: writes are dropped, reads return 0, and the pointer still increments mod 2^ADDR_W.
- write and read both high: write wins; read is ignored and data_out holds.
- STATUS read: [31:24]=0, [23:16]=mask, [15:9]=0, [8]=busy, [7:0]=flags.
- STATUS write: mask <= data_in[23:16]; each flag bit i with data_in[i]=1 is cleared (write-1-to-clear).
- start (en_s=1, busy=0): core_start=1 for the next cycle only, and busy<=1. start while busy is ignored.
- core_done: flags[0]<=1, busy<=0. Same-cycle done and host clear: set wins.
- int_req = ~|(flags & mask), registered, so it lags the flag/mask change by one cycle.
- Core Z write and host read of the same Z address in the same cycle: the read returns the old value.
- Reset asserted mid-burst or mid-run: all state above returns to reset values; core_start is not emitted.

Optional Feature:
AIP_ERR_INT_EN
- Defined: flags[1] is set on any of:
  - host write to MdataZ
  - memory access with ptr >= MEM_DEPTH
  - start while busy
  flags[1] is cleared and masked like flags[0] and contributes to int_req.
- Undefined: flags[1] reads 0; mask[1] is stored but has no effect.

Test Plan:
- Reset, read IP_ID and STATUS -> data_out 32'h1000500A, then 32'h00000000; int_req=1.
- Write pointer 0 then 5 words {3,1,4,0,2} to MdataX and 4 words {2,2,1,3} to MdataY; core_x_addr=2 -> core_x_data=4; core_y_addr=3 -> core_y_data=3; read back X from pointer 0 -> same 5 words, each one cycle after its strobe.
- Write Csize = (4<<5)|5 -> cfg_size=32'h85. Write STATUS 32'h00010000, pulse start -> core_start high exactly one cycle; STATUS bit8=1; a second start before done gives no core_start pulse.
- Core writes Z[0..8]=k*7 then pulses core_done -> int_req falls one cycle later; STATUS reads 32'h00010001; host reads MdataZ from 0 -> 0,7,...,56.
- Write STATUS 32'h00010001 -> flags clear, int_req returns to 1; core_done in the same cycle as a clear -> flag stays 1.
- Set pointer 8, write 2 words -> second write lands in word 0 (wrap); pointer 12, read -> 0. With AIP_ERR_INT_EN and mask 32'h00020000: int_req goes low, STATUS bit1=1.
